// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for an N-stage in-order pipeline.
// It produces the load and flush strobes for the PC and for each pipeline register.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int EX_STAGE    = 2,
  parameter int MEM_STAGE   = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_resp,
  input  logic                  dmem_resp,
  input  logic                  dmem_req,
  input  logic                  load_use,
  input  logic                  redirect,
  output logic                  imem_read,
  output logic                  load_pc,
  output logic [NUM_STAGES-2:0] load_reg,
  output logic [NUM_STAGES-2:0] flush_reg,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  generate
    if (!(EX_STAGE >= 1 && MEM_STAGE > EX_STAGE && MEM_STAGE < NUM_STAGES &&
          FLUSH_DEPTH <= EX_STAGE)) begin : g_param_check
      $error("pipe_hazard_ctrl: illegal stage parameters");
    end
  endgenerate

  logic imem_done_reg, imem_done_next;
  logic dmem_done_reg, dmem_done_next;
  logic i_ok, d_ok, adv, bubble;
  logic [2:0] cnt_inc;
  logic [CNT_W-1:0] cnt_reg [3];

  always_comb begin
    i_ok   = imem_resp | imem_done_reg;
    d_ok   = ~dmem_req | dmem_resp | dmem_done_reg;
    adv    = rst & i_ok & d_ok;
    bubble = load_use & ~redirect;
    // A response that completes in the advancing cycle is consumed immediately.
    imem_done_next = adv ? 1'b0 : (imem_done_reg | imem_resp);
    dmem_done_next = adv ? 1'b0 : (dmem_done_reg | dmem_resp);
    imem_read  = rst & ~imem_done_reg;
    load_pc    = adv & ~bubble;
    cnt_inc[0] = rst & ~adv;
    cnt_inc[1] = adv & bubble;
    cnt_inc[2] = adv & redirect;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_done_reg <= 1'b0;
      dmem_done_reg <= 1'b0;
    end else begin
      imem_done_reg <= imem_done_next;
      dmem_done_reg <= dmem_done_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES - 1; gi++) begin : g_reg
      localparam logic HOLD_BIT   = (gi < EX_STAGE - 1);
      localparam logic BUBBLE_BIT = (gi == EX_STAGE - 1);
      localparam logic FLUSH_BIT  = (gi < FLUSH_DEPTH);
      // Registers younger than the bubble slot hold so the ID instruction retries.
      assign load_reg[gi]  = adv & ~(bubble & HOLD_BIT);
      assign flush_reg[gi] = adv & (redirect ? FLUSH_BIT : (load_use & BUBBLE_BIT));
    end

    for (gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != '1)) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
        end
      end
    end
  endgenerate

  assign stall_cnt  = cnt_reg[0];
  assign bubble_cnt = cnt_reg[1];
  assign flush_cnt  = cnt_reg[2];

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised successor to the fixed 5-stage hazard control unit; generates pipeline-register load/flush strobes for an N-stage in-order pipeline.
- Tolerates multi-cycle, independently timed imem/dmem responses: completed responses are latched, and the pipeline advances only once every outstanding request has finished.
- Inserts load-use bubbles and flushes younger stages on a taken branch or jump.
- Maintains saturating stall/bubble/flush performance counters. Sits beside the datapath in the CPU top.

Parameters:
- NUM_STAGES, 5: pipeline stages; stage 0 = IF. Pipeline register i sits between stage i and stage i+1.
- EX_STAGE, 2: index of the stage that resolves redirects. Load-use bubble is injected into register EX_STAGE-1.
- MEM_STAGE, 3: index of the stage issuing dmem requests. Must be greater than EX_STAGE and less than NUM_STAGES.
- FLUSH_DEPTH, 2: number of pipeline registers (0..FLUSH_DEPTH-1) flushed on redirect. Must be ≤ EX_STAGE.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- imem_resp  in  1  fetch completes this cycle
- dmem_resp  in  1  data access completes this cycle
- dmem_req  in  1  MEM stage holds a valid load/store (level, stable until advance)
- load_use  in  1  ID instruction depends on EX-stage load
- redirect  in  1  EX stage branch taken / jump
- imem_read  out  1  fetch request
- load_pc  out  1  PC register load
- load_reg  out  NUM_STAGES-1  per-pipeline-register load
- flush_reg  out  NUM_STAGES-1  per-register synchronous clear to bubble (meaningful only when paired with load_reg)
- stall_cnt  out  CNT_W  cycles with no advance
- bubble_cnt  out  CNT_W  load-use bubbles inserted
- flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Sticky flags imem_done and dmem_done. Set on the corresponding resp when not advancing; cleared on advance.
- i_ok = imem_resp | imem_done.
- d_ok = ~dmem_req | dmem_resp | dmem_done.
- adv = i_ok & d_ok, computed combinationally in the same cycle as the resp.
- imem_read = ~imem_done. It stays high through a dmem stall until the fetch returns, then drops until advance.
- dmem_read/write gating stays in the datapath; this block only observes dmem_req.
- adv=0: load_pc=0, load_reg=0, flush_reg=0; stall_cnt increments.
- adv=1, normal: load_pc=1, load_reg all 1, flush_reg 0.
- adv=1 & redirect:
  - load_pc=1 (target mux is in the datapath), load_reg all 1.
  - flush_reg[FLUSH_DEPTH-1:0]=1.
  - flush_cnt increments.
  - redirect has priority over load_use: the load_use instruction is squashed, so no bubble and bubble_cnt does not increment.
- adv=1 & load_use & ~redirect:
  - load_pc=0; load_reg[EX_STAGE-2:0]=0 (hold IF..ID).
  - load_reg[EX_STAGE-1]=1 with flush_reg[EX_STAGE-1]=1 (bubble); all older registers load.
  - bubble_cnt increments.
  - The held PC refetches the same address next cycle.
- imem_resp and dmem_resp in the same cycle give adv if all other conditions are met. No flag is set.
- Response arriving while its flag is already set: protocol violation; the flag stays set.
- Counters saturate at all-ones and never wrap. Each event increments its counter by at most 1 per cycle.
- Reset (rst=0), asynchronous and possibly mid-stall:
  - flags, counters and strobes are cleared immediately; imem_read=0 while in reset.
  - An in-flight memory response arriving during reset is ignored.
  - First cycle after release: imem_read=1, all strobes 0 until the first adv.
- All strobes are combinational from registered flags and inputs; flags and counters update on posedge clk.

Test Plan:
- Single-cycle memories, imem_resp=1 every cycle, dmem_req=0 → adv every cycle; load_reg=4'b1111, load_pc=1; after 10 cycles stall_cnt=0.
- imem_resp at cycle 1, dmem_req=1, dmem_resp at cycle 4 → imem_done set at cycle 1, imem_read=0 in cycles 2–4; single advance at cycle 4; stall_cnt=3; both flags clear at cycle 5.
- load_use=1 on an adv cycle (defaults) → load_pc=0, load_reg=4'b1110, flush_reg=4'b0010; bubble_cnt 0→1.
- redirect=1 and load_use=1 on an adv cycle → load_pc=1, load_reg=4'b1111, flush_reg=4'b0011; flush_cnt=1, bubble_cnt unchanged.
- CNT_W=4, stall held 20 cycles → stall_cnt saturates at 15.
- rst driven low asynchronously mid dmem stall with imem_done=1 → flags and counters 0 immediately; imem_read=1 on the first cycle after release.
- NUM_STAGES=7, EX_STAGE=3, FLUSH_DEPTH=3 → redirect gives flush_reg=6'b000111; load_use gives load_reg=6'b111100 and flush_reg=6'b000100.
